backtrack_ctrl: RTL and testbench

BACKTRACK_CTRL -- requirements
Module: backtrack_ctrl

---
 rtl/common.sv | 18 +
 rtl/Stack_bool.sv | 36 +++
 rtl/backtrack_ctrl.sv | 125 ++++++++++++
 tb/tb_backtrack_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared constants and types for the backtracking controller and its bool stack.
package common;

    localparam int unsigned bool_stack_size       = 8;
    localparam int unsigned width_bool_stack_size = $clog2(bool_stack_size);

    typedef logic [width_bool_stack_size:0] level_t;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        WAIT,
        FLIP,
        RESUME,
        UNSAT
    } bt_state_t;

endpackage

// File: rtl/Stack_bool.sv
// Single-bit LIFO holding one flipped-flag per decision level.
module Stack_bool
    import common::*;
(
    input  logic clock,
    input  logic reset,
    input  logic wr_en,
    input  logic pop,
    input  logic din,
    output logic front_c,
    output logic full_c,
    output logic empty_c
);

    localparam int unsigned addr_w = width_bool_stack_size;

    logic [bool_stack_size-1:0] mem;
    level_t                     ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem <= '0;
            ptr <= '0;
        end else if (wr_en && !full_c) begin
            mem[addr_w'(ptr)] <= din;
            ptr               <= level_t'(ptr + 1'b1);
        end else if (pop && !empty_c) begin
            ptr <= level_t'(ptr - 1'b1);
        end
    end

    assign full_c  = (ptr == level_t'(bool_stack_size));
    assign empty_c = (ptr == '0);
    assign front_c = empty_c ? 1'b0 : mem[addr_w'(ptr - 1'b1)];

endmodule

// File: rtl/backtrack_ctrl.sv
// Decision-level / chronological backtracking controller; sole master of the bool stack.
module backtrack_ctrl
    import common::*;
(
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           decide_req,
    input  logic                           conflict_req,
    output logic                           stk_wr_en,
    output logic                           stk_pop,
    output logic                           stk_din,
    input  logic                           stk_front,
    input  logic                           stk_full,
    input  logic                           stk_empty,
    output logic                           decide_ack,
    output logic                           bt_done,
    output logic [width_bool_stack_size:0] bt_level,
    output logic [width_bool_stack_size:0] level,
    output logic                           busy,
    output logic                           unsat,
    output logic                           overflow
);

    bt_state_t state, state_n;
    level_t    level_n, bt_level_n;
    logic      wr_en_n, pop_n, din_n, ack_n, done_n, busy_n, unsat_n, overflow_n;

    // Depth is tracked by the level counter; stack status is observed only.
    logic unused_stk_status;
    assign unused_stk_status = stk_full ^ stk_empty;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            level      <= '0;
            bt_level   <= '0;
            stk_wr_en  <= 1'b0;
            stk_pop    <= 1'b0;
            stk_din    <= 1'b0;
            decide_ack <= 1'b0;
            bt_done    <= 1'b0;
            busy       <= 1'b0;
            unsat      <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            level      <= level_n;
            bt_level   <= bt_level_n;
            stk_wr_en  <= wr_en_n;
            stk_pop    <= pop_n;
            stk_din    <= din_n;
            decide_ack <= ack_n;
            bt_done    <= done_n;
            busy       <= busy_n;
            unsat      <= unsat_n;
            overflow   <= overflow_n;
        end
    end

    // Outputs are registered, so each branch sets the value seen in the following state.
    always_comb begin
        state_n    = state;
        level_n    = level;
        bt_level_n = bt_level;
        unsat_n    = unsat;
        overflow_n = overflow;
        wr_en_n    = 1'b0;
        pop_n      = 1'b0;
        din_n      = 1'b0;
        ack_n      = 1'b0;
        done_n     = 1'b0;
        busy_n     = 1'b0;
        case (state)
            IDLE: begin
                if (conflict_req) begin
                    if (level == '0) begin
                        state_n = UNSAT;
                        unsat_n = 1'b1;
                    end else begin
                        state_n = SCAN;
                        busy_n  = 1'b1;
                    end
                end else if (decide_req) begin
                    if (level < level_t'(bool_stack_size)) begin
                        wr_en_n = 1'b1;
                        level_n = level_t'(level + 1'b1);
                        ack_n   = 1'b1;
                    end else begin
                        overflow_n = 1'b1;
                    end
                end
            end
            SCAN: begin
                busy_n = 1'b1;
                pop_n  = 1'b1;
                if (stk_front) begin
                    level_n = level_t'(level - 1'b1);
                    state_n = WAIT;
                end else begin
                    state_n = FLIP;
                end
            end
            WAIT: begin
                if (level == '0) begin
                    state_n = UNSAT;
                    unsat_n = 1'b1;
                end else begin
                    state_n = SCAN;
                    busy_n  = 1'b1;
                end
            end
            FLIP: begin
                wr_en_n    = 1'b1;
                din_n      = 1'b1;
                done_n     = 1'b1;
                bt_level_n = level;
                state_n    = RESUME;
            end
            RESUME: state_n = IDLE;
            UNSAT:  state_n = UNSAT;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_backtrack_ctrl.sv
// Scoreboard bench for backtrack_ctrl with a queue-based reference model of the decision stack.
module tb_backtrack_ctrl;
    import common::*;

    localparam int K_ACK   = 0;
    localparam int K_DONE  = 1;
    localparam int K_UNSAT = 2;

    typedef struct {
        int kind;
        int lvl;
        int btl;
        int cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic decide_req = 1'b0;
    logic conflict_req = 1'b0;
    logic stk_wr_en, stk_pop, stk_din, stk_front, stk_full, stk_empty;
    logic decide_ack, bt_done, busy, unsat, overflow;
    logic [width_bool_stack_size:0] bt_level, level;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    bit   mstk[$];
    bit   m_unsat = 0;
    bit   m_overflow = 0;
    bit   unsat_seen = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    backtrack_ctrl dut (
        .clock(clock), .reset(reset),
        .decide_req(decide_req), .conflict_req(conflict_req),
        .stk_wr_en(stk_wr_en), .stk_pop(stk_pop), .stk_din(stk_din),
        .stk_front(stk_front), .stk_full(stk_full), .stk_empty(stk_empty),
        .decide_ack(decide_ack), .bt_done(bt_done), .bt_level(bt_level),
        .level(level), .busy(busy), .unsat(unsat), .overflow(overflow)
    );

    Stack_bool stack (
        .clock(clock), .reset(reset),
        .wr_en(stk_wr_en), .pop(stk_pop), .din(stk_din),
        .front_c(stk_front), .full_c(stk_full), .empty_c(stk_empty)
    );

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic mon_event(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            chk("event_level", int'(level), e.lvl);
            if (kind == K_DONE) chk("bt_level", int'(bt_level), e.btl);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    always @(negedge clock) begin
        if (!reset) begin
            chk("push_pop_overlap", int'(stk_wr_en & stk_pop), 0);
            if (decide_ack) mon_event(K_ACK);
            if (bt_done) mon_event(K_DONE);
            if (unsat && !unsat_seen) begin
                unsat_seen = 1;
                mon_event(K_UNSAT);
            end
        end
    end

    task automatic model_clear();
        exp_q.delete();
        mstk.delete();
        m_unsat = 0;
        m_overflow = 0;
        unsat_seen = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        decide_req = 1'b0;
        conflict_req = 1'b0;
        model_clear();
        @(negedge clock);
        chk("reset_outputs", int'({stk_wr_en, stk_pop, stk_din, decide_ack, bt_done,
                                   busy, unsat, overflow, bt_level, level}), 0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Reference: conflict pops every flipped level, then flips the first unflipped one.
    task automatic model_request(input bit d, input bit c, input int c0);
        exp_t e;
        int   k;
        if (m_unsat) return;
        if (c) begin
            k = 0;
            while (mstk.size() > 0 && mstk[mstk.size()-1] == 1'b1) begin
                void'(mstk.pop_back());
                k++;
            end
            if (mstk.size() == 0) begin
                m_unsat = 1;
                e = '{K_UNSAT, 0, 0, c0 + 1 + 2*k};
            end else begin
                mstk[mstk.size()-1] = 1'b1;
                e = '{K_DONE, mstk.size(), mstk.size(), c0 + 3 + 2*k};
            end
            exp_q.push_back(e);
        end else if (d) begin
            if (mstk.size() < bool_stack_size) begin
                mstk.push_back(1'b0);
                e = '{K_ACK, mstk.size(), 0, c0 + 1};
                exp_q.push_back(e);
            end else begin
                m_overflow = 1;
            end
        end
    endtask

    task automatic issue(input bit d, input bit c, input bit junk);
        int n;
        @(negedge clock);
        decide_req = d;
        conflict_req = c;
        model_request(d, c, cyc);
        @(negedge clock);
        decide_req = 1'b0;
        conflict_req = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clock);
            if (junk && busy && $urandom_range(0, 2) == 0) begin
                decide_req = 1'b1;
                conflict_req = 1'($urandom_range(0, 1));
            end else begin
                decide_req = 1'b0;
                conflict_req = 1'b0;
            end
            n++;
        end
        decide_req = 1'b0;
        conflict_req = 1'b0;
        if (exp_q.size() != 0) begin
            chk("response_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clock);
    endtask

    task automatic check_state();
        chk("level", int'(level), mstk.size());
        chk("unsat", int'(unsat), int'(m_unsat));
        chk("overflow", int'(overflow), int'(m_overflow));
        chk("busy_idle", int'(busy), 0);
        if (!m_unsat && mstk.size() > 0) chk("stack_top", int'(stk_front), int'(mstk[mstk.size()-1]));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // three decisions, then two chronological backtracks
        repeat (3) issue(1, 0, 0);
        check_state();
        chk("stack_first_branch", int'(stk_front), 0);
        issue(0, 1, 0);
        check_state();
        issue(0, 1, 0);
        check_state();

        // all levels already flipped: unsat, then requests ignored
        do_reset();
        repeat (3) begin
            issue(1, 0, 0);
            issue(0, 1, 0);
        end
        check_state();
        issue(0, 1, 0);
        check_state();
        issue(1, 0, 0);
        issue(0, 1, 0);
        check_state();

        // overflow, then conflict beats decide in the same cycle
        do_reset();
        repeat (bool_stack_size + 1) issue(1, 0, 0);
        check_state();
        issue(1, 1, 0);
        check_state();

        // reset while waiting on the stack update abandons the backtrack
        do_reset();
        repeat (2) issue(1, 0, 0);
        issue(0, 1, 0);
        @(negedge clock);
        conflict_req = 1'b1;
        @(negedge clock);
        conflict_req = 1'b0;
        @(negedge clock);
        chk("busy_in_wait", int'(busy), 1);
        chk("level_in_wait", int'(level), 1);
        reset = 1'b1;
        model_clear();
        @(posedge clock);
        #1;
        chk("reset_mid_bt", int'({stk_wr_en, stk_pop, stk_din, decide_ack, bt_done,
                                  busy, unsat, overflow, bt_level, level}), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        issue(1, 0, 0);
        check_state();

        // randomized mix with junk requests while busy
        do_reset();
        for (int i = 0; i < 200; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) do_reset();
            else if (r < 60) issue(1, 0, 1);
            else if (r < 94) issue(0, 1, 1);
            else issue(1, 1, 1);
            check_state();
        end

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
